// File: rtl/online_ccm_seq_pkg.sv
// Shared types and helpers for the time-multiplexed constant-coefficient multiplier.
// Signed digits are two bits wide: the high bit adds +1 and the low bit adds -1.
package online_ccm_seq_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAdd  = 2'd1,
        StDone = 2'd2
    } state_t;

    localparam int unsigned PosBit = 1;
    localparam int unsigned NegBit = 0;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r++;
        end
        return r;
    endfunction

    // Value of an SD vector: sum over digits of (pos - neg) * 2^i.
    function automatic longint sd_decode(input logic [63:0] v, input int unsigned ndig);
        longint r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if (i < ndig) begin
                if (v[2*i+PosBit]) r = r + (longint'(1) <<< i);
                if (v[2*i+NegBit]) r = r - (longint'(1) <<< i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/online_adder.sv
// Carry-free radix-2 signed-digit adder: N-digit a + b + cin giving N+1 digits.
// Each position splits its digit sum into a transfer and an interim digit so no carry ripples.
module online_adder
    import online_ccm_seq_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic [2*N-1:0] a,
    input  logic [2*N-1:0] b,
    input  logic           cin,
    output logic [2*N+1:0] s
);

    logic signed [2:0] dsum [N];
    logic [N-1:0] low_nonneg;
    logic [N-1:0] tp, tn, wp, wn;

    always_comb begin
        tp = '0;
        tn = '0;
        wp = '0;
        wn = '0;
        low_nonneg = '0;
        for (int i = 0; i < N; i++) begin
            dsum[i] = $signed({2'b00, a[2*i+PosBit]}) - $signed({2'b00, a[2*i+NegBit]})
                    + $signed({2'b00, b[2*i+PosBit]}) - $signed({2'b00, b[2*i+NegBit]});
            // A lower position holding no -1 digit can only send a transfer of 0 or +1.
            if (i == 0) begin
                low_nonneg[i] = 1'b1;
            end else begin
                low_nonneg[i] = !(a[2*(i-1)+NegBit] && !a[2*(i-1)+PosBit])
                             && !(b[2*(i-1)+NegBit] && !b[2*(i-1)+PosBit]);
            end
            case (dsum[i])
                3'sb010: tp[i] = 1'b1;
                3'sb110: tn[i] = 1'b1;
                3'sb001: begin
                    if (low_nonneg[i]) begin
                        tp[i] = 1'b1;
                        wn[i] = 1'b1;
                    end else begin
                        wp[i] = 1'b1;
                    end
                end
                3'sb111: begin
                    if (low_nonneg[i]) begin
                        wn[i] = 1'b1;
                    end else begin
                        tn[i] = 1'b1;
                        wp[i] = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        s = '0;
        s[2*0+PosBit] = (wp[0] && !cin) ? 1'b1 : (cin && !wn[0] && !wp[0]);
        s[2*0+NegBit] = wn[0] && !cin;
        for (int i = 1; i < N; i++) begin
            s[2*i+PosBit] = (wp[i] && !tn[i-1]) || (tp[i-1] && !wn[i]);
            s[2*i+NegBit] = (wn[i] && !tp[i-1]) || (tn[i-1] && !wp[i]);
        end
        s[2*N+PosBit] = tp[N-1];
        s[2*N+NegBit] = tn[N-1];
    end

endmodule

// File: rtl/online_ccm_seq_term_gen.sv
// Builds one coefficient term: operand shifted up by a digit count, optionally negated.
// Negation of an SD number is a swap of the two bits in every digit.
module sd_term_gen
    import online_ccm_seq_pkg::*;
#(
    parameter int unsigned Stage = 4,
    parameter int unsigned DA    = 14,
    parameter int unsigned SW    = 3
) (
    input  logic [2*Stage-1:0] x,
    input  logic [SW-1:0]      shift,
    input  logic               neg,
    output logic [2*DA-1:0]    term
);

    logic [2*DA-1:0] shifted;

    always_comb begin
        shifted = {{(2*(DA-Stage)){1'b0}}, x} << {shift, 1'b0};
        term = '0;
        for (int i = 0; i < DA; i++) begin
            term[2*i+PosBit] = neg ? shifted[2*i+NegBit] : shifted[2*i+PosBit];
            term[2*i+NegBit] = neg ? shifted[2*i+PosBit] : shifted[2*i+NegBit];
        end
    end

endmodule

// File: rtl/online_ccm_seq.sv
// Run-time coefficient multiplier: accumulates up to NTERM signed power-of-two multiples of x
// through one shared SD adder, one enabled term per cycle, lowest index first.
module online_ccm_seq
    import online_ccm_seq_pkg::*;
#(
    parameter int unsigned Stage = 4,
    parameter int unsigned SMAX  = 7,
    parameter int unsigned NTERM = 4,
    localparam int unsigned SW      = clog2(SMAX + 1),
    localparam int unsigned ACC_DIG = Stage + SMAX + NTERM,
    localparam int unsigned DA      = ACC_DIG - 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*Stage-1:0]   x,
    input  logic [NTERM*SW-1:0]  coef_shift,
    input  logic [NTERM-1:0]     coef_sign,
    input  logic [NTERM-1:0]     coef_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*ACC_DIG-1:0] y,
    output logic                 ovf
);

    state_t state_q, state_d;
    logic [2*Stage-1:0]   x_q, x_d;
    logic [NTERM*SW-1:0]  shift_q, shift_d;
    logic [NTERM-1:0]     sign_q, sign_d;
    logic [NTERM-1:0]     mask_q, mask_d;
    logic [2*ACC_DIG-1:0] acc_q, acc_d;
    logic                 ovf_q, ovf_d;

    logic [SW-1:0]        cur_shift;
    logic                 cur_sign;
    logic [NTERM-1:0]     cur_onehot;
    logic [2*DA-1:0]      term;
    logic [2*ACC_DIG-1:0] sum;

    // Downward scan so the lowest pending index wins.
    always_comb begin
        cur_shift  = '0;
        cur_sign   = 1'b0;
        cur_onehot = '0;
        for (int j = NTERM - 1; j >= 0; j--) begin
            if (mask_q[j]) begin
                cur_shift  = shift_q[j*SW +: SW];
                cur_sign   = sign_q[j];
                cur_onehot = '0;
                cur_onehot[j] = 1'b1;
            end
        end
    end

    sd_term_gen #(
        .Stage (Stage),
        .DA    (DA),
        .SW    (SW)
    ) u_term_gen (
        .x     (x_q),
        .shift (cur_shift),
        .neg   (cur_sign),
        .term  (term)
    );

    online_adder #(
        .N (DA)
    ) u_adder (
        .a   (acc_q[2*DA-1:0]),
        .b   (term),
        .cin (1'b0),
        .s   (sum)
    );

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        shift_d = shift_q;
        sign_d  = sign_q;
        mask_d  = mask_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    x_d     = x;
                    shift_d = coef_shift;
                    sign_d  = coef_sign;
                    mask_d  = coef_en;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = (|coef_en) ? StAdd : StDone;
                end
            end
            StAdd: begin
                acc_d  = sum;
                mask_d = mask_q & ~cur_onehot;
                // The adder only sees DA digits, so a live top digit is about to be dropped.
                if (|acc_q[2*ACC_DIG-1:2*DA]) ovf_d = 1'b1;
                if ((mask_q & ~cur_onehot) == '0) state_d = StDone;
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            x_q     <= '0;
            shift_q <= '0;
            sign_q  <= '0;
            mask_q  <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            shift_q <= shift_d;
            sign_q  <= sign_d;
            mask_q  <= mask_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign y         = acc_q;
    assign ovf       = ovf_q;

endmodule
